// File: rtl/controlador_vitais_pkg.sv
// Shared activity codes, life-FSM encoding and level arithmetic helpers for the vital-signs block.
package controlador_vitais_pkg;

    typedef enum logic [3:0] {
        EstIdle      = 4'b0000,
        EstDormindo  = 4'b0001,
        EstComendo   = 4'b0010,
        EstDandoAula = 4'b0100,
        EstMorto     = 4'b1000
    } estado_e;

    typedef enum logic [1:0] {
        VidaVivo    = 2'd0,
        VidaCritico = 2'd1,
        VidaMorto   = 2'd2
    } vida_e;

    typedef struct packed {
        logic signed [5:0] fome;
        logic signed [5:0] sono;
        logic signed [5:0] tedio;
    } deltas_t;

    function automatic deltas_t deltas_por_estado(input logic [3:0] estado);
        deltas_t d;
        d.fome  = 6'sd0;
        d.sono  = 6'sd0;
        d.tedio = 6'sd0;
        case (estado)
            EstIdle: begin
                d.fome  = 6'sd1;
                d.sono  = 6'sd1;
                d.tedio = 6'sd1;
            end
            EstDormindo: begin
                d.fome  = 6'sd1;
                d.sono  = -6'sd2;
            end
            EstComendo: begin
                d.fome  = -6'sd3;
                d.sono  = 6'sd1;
            end
            EstDandoAula: begin
                d.fome  = 6'sd2;
                d.sono  = 6'sd2;
                d.tedio = -6'sd3;
            end
            default: ;
        endcase
        return d;
    endfunction

    // Levels saturate at both ends; the 6-bit signed sum covers -3..18 without overflow.
    function automatic logic [3:0] clamp_nivel(input logic [3:0]        nivel,
                                               input logic signed [5:0] delta,
                                               input logic [3:0]        max_nivel);
        logic signed [5:0] soma;
        soma = $signed({2'b00, nivel}) + delta;
        if (soma < 6'sd0) begin
            return 4'd0;
        end else if (soma > $signed({2'b00, max_nivel})) begin
            return max_nivel;
        end
        return soma[3:0];
    endfunction

endpackage

// File: rtl/controlador_vitais_if.sv
// Activity code in, need levels and life flags out; master is the vitals block, slave the state
// controller.
interface controlador_vitais_if;
    logic [3:0] estado;
    logic [3:0] fome;
    logic [3:0] sono;
    logic [3:0] tedio;
    logic       alerta;
    logic       morreu;

    modport master (input estado, output fome, sono, tedio, alerta, morreu);
    modport slave  (output estado, input fome, sono, tedio, alerta, morreu);
endinterface

// File: rtl/controlador_vitais_divisor_tick.sv
// Game-time prescaler: one-cycle tick every TICK_DIV clocks, reusable for animation timing.
module divisor_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] Ultimo = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == Ultimo) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tick = (cnt_q == Ultimo);

endmodule

// File: rtl/controlador_vitais.sv
// Vital-signs scheduler: advances fome/sono/tedio once per game tick and sequences life/death.
module controlador_vitais
    import controlador_vitais_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned MAX_NIVEL     = 15,
    parameter int unsigned NIVEL_INICIAL = 4,
    parameter int unsigned LIMITE_TICKS  = 3
) (
    input logic                   clk,
    input logic                   rst,
    controlador_vitais_if.master  vitais
);
    localparam int unsigned CntW = $clog2(LIMITE_TICKS + 1);
    localparam logic [3:0] MaxW = 4'(MAX_NIVEL);
    localparam logic [3:0] InicialW = 4'(NIVEL_INICIAL);
    localparam logic [CntW-1:0] LimiteW = CntW'(LIMITE_TICKS);

    logic            tick;
    deltas_t         delta;
    logic [3:0]      fome_novo, sono_novo, tedio_novo;
    logic            critico;
    logic [3:0]      fome_q, fome_d, sono_q, sono_d, tedio_q, tedio_d;
    vida_e           vida_q, vida_d;
    logic [CntW-1:0] crit_q, crit_d;
    logic            alerta_q, alerta_d, morreu_q, morreu_d;

    divisor_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_divisor (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_comb begin
        delta      = deltas_por_estado(vitais.estado);
        fome_novo  = clamp_nivel(fome_q, delta.fome, MaxW);
        sono_novo  = clamp_nivel(sono_q, delta.sono, MaxW);
        tedio_novo = clamp_nivel(tedio_q, delta.tedio, MaxW);
        critico    = (fome_novo == MaxW) || (sono_novo == MaxW) || (tedio_novo == MaxW);

        fome_d  = fome_q;
        sono_d  = sono_q;
        tedio_d = tedio_q;
        vida_d  = vida_q;
        crit_d  = crit_q;

        // Levels still move on the tick that enters VidaMorto, then freeze.
        if (tick && (vida_q != VidaMorto)) begin
            fome_d  = fome_novo;
            sono_d  = sono_novo;
            tedio_d = tedio_novo;
            case (vida_q)
                VidaVivo: begin
                    if (critico) begin
                        crit_d = CntW'(1);
                        vida_d = (LIMITE_TICKS == 1) ? VidaMorto : VidaCritico;
                    end
                end
                VidaCritico: begin
                    if (critico) begin
                        crit_d = crit_q + CntW'(1);
                        if (crit_q + CntW'(1) == LimiteW) begin
                            vida_d = VidaMorto;
                        end
                    end else begin
                        crit_d = '0;
                        vida_d = VidaVivo;
                    end
                end
                default: ;
            endcase
        end

        alerta_d = (vida_d == VidaCritico);
        morreu_d = (vida_d == VidaMorto);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fome_q   <= InicialW;
            sono_q   <= InicialW;
            tedio_q  <= InicialW;
            vida_q   <= VidaVivo;
            crit_q   <= '0;
            alerta_q <= 1'b0;
            morreu_q <= 1'b0;
        end else begin
            fome_q   <= fome_d;
            sono_q   <= sono_d;
            tedio_q  <= tedio_d;
            vida_q   <= vida_d;
            crit_q   <= crit_d;
            alerta_q <= alerta_d;
            morreu_q <= morreu_d;
        end
    end

    assign vitais.fome   = fome_q;
    assign vitais.sono   = sono_q;
    assign vitais.tedio  = tedio_q;
    assign vitais.alerta = alerta_q;
    assign vitais.morreu = morreu_q;

endmodule
